// File: rtl/config_int_add_in_mux_truncation.sv
// ============================================================================
// config_int_add_in_mux_truncation
//
// Purpose:
//   Registered two's-complement adder whose low bits can be truncated at run
//   time. The operands and the mode bit are captured together in one input
//   register stage. In approximate mode the low L = W - H bits of both
//   operands are forced to zero before the add, so the upper H bits are
//   summed with no carry-in from below. The low-bit result is zero.
//
//   The adder is split into a low slice (L bits) and a high slice (H bits).
//   The low slice is fed through the input mux, so in approximate mode it
//   sees constant zeros and does not toggle. Its carry-out chains into the
//   high slice, so exact mode gives the full W-bit sum modulo 2^W.
//
// Configuration macro:
//   CFG_ADD_OUT_REG_EN  defined   -> c is registered (latency 2 edges)
//                       undefined -> c is combinational from the adder
//                                    (latency 1 edge)
//   The arithmetic is the same in both builds. Only the latency changes.
//
// Parameters:
//   DATA_PATH_BITWIDTH  W, operand and result width (default 32)
//   HRDWIRED_BITWIDTH   H, upper bits always computed exactly (default 16),
//                       legal range 1 <= H <= W
//
// Ports:
//   clk      in  1   rising-edge clock
//   rst      in  1   asynchronous active-low reset; clears every register
//   apx_ctl  in  1   1 = approximate (truncating), 0 = exact
//   a        in  W   operand A
//   b        in  W   operand B
//   c        out W   sum
// ============================================================================
module config_int_add_in_mux_truncation #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int HRDWIRED_BITWIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          apx_ctl,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic [DATA_PATH_BITWIDTH-1:0] c
);

    localparam int W = DATA_PATH_BITWIDTH;
    localparam int H = HRDWIRED_BITWIDTH;
    localparam int L = W - H;

    logic [W-1:0] r_a_q;
    logic [W-1:0] r_b_q;
    logic         r_apx_q;
    logic [W-1:0] w_s;

    // The mode bit is captured in the same stage as the operands. As a
    // result, a result can never mix the mode of one sample with the
    // operands of another.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_apx_q <= 1'b0;
        end else begin
            r_a_q   <= a;
            r_b_q   <= b;
            r_apx_q <= apx_ctl;
        end
    end

    generate
        if (L == 0) begin : g_exact_only
            // No approximable bits. The mode bit has nothing to gate.
            logic w_unused_apx;
            assign w_unused_apx = r_apx_q;
            assign w_s          = r_a_q + r_b_q;
        end else begin : g_split
            logic [L-1:0] w_ga_lo;
            logic [L-1:0] w_gb_lo;
            logic [L:0]   w_sum_lo;
            logic [H-1:0] w_sum_hi;

            // Input mux for the low slice. Zeros here keep the low adder
            // quiet, and they also remove its carry into the high slice.
            assign w_ga_lo  = r_apx_q ? '0 : r_a_q[L-1:0];
            assign w_gb_lo  = r_apx_q ? '0 : r_b_q[L-1:0];
            assign w_sum_lo = {1'b0, w_ga_lo} + {1'b0, w_gb_lo};

            // The upper bits pass through unchanged in both modes. The carry
            // out of the top is dropped, so the sum wraps modulo 2^W.
            assign w_sum_hi = r_a_q[W-1:L] + r_b_q[W-1:L] + H'(w_sum_lo[L]);

            assign w_s = {w_sum_hi, w_sum_lo[L-1:0]};
        end
    endgenerate

`ifdef CFG_ADD_OUT_REG_EN
    logic [W-1:0] r_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c <= '0;
        end else begin
            r_c <= w_s;
        end
    end

    assign c = r_c;
`else
    // The input registers clear to zero during reset, so c is also zero.
    assign c = w_s;
`endif

endmodule

// File: tb/tb_config_int_add_in_mux_truncation.sv
`timescale 1ns/1ps
module tb_config_int_add_in_mux_truncation;

    localparam int W = 32;
    localparam int H = 16;
    localparam int L = W - H;
`ifdef CFG_ADD_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          apx_ctl = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  c;
    logic [W-1:0]  c_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    config_int_add_in_mux_truncation #(
        .DATA_PATH_BITWIDTH(W),
        .HRDWIRED_BITWIDTH (H)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .apx_ctl (apx_ctl),
        .a       (a),
        .b       (b),
        .c       (c)
    );

    // Instance with every bit hardwired: the mode input must be irrelevant.
    config_int_add_in_mux_truncation #(
        .DATA_PATH_BITWIDTH(W),
        .HRDWIRED_BITWIDTH (W)
    ) dut_full (
        .clk     (clk),
        .rst     (rst),
        .apx_ctl (apx_ctl),
        .a       (a),
        .b       (b),
        .c       (c_full)
    );

    // ---------------- reference model ----------------
    // Approximate: add only the upper H bits, then place them back above L
    // zero bits. The left shift drops the high carry, which gives mod 2^H.
    function automatic logic [W-1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         m);
        logic [W-1:0] r;
        if (m) r = ((x >> L) + (y >> L)) << L;
        else   r = x + y;
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic m);
        a       = x;
        b       = y;
        apx_ctl = m;
    endtask

    task automatic wait_latency();
        repeat (LAT) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive($urandom(), $urandom(), 1'($urandom_range(0, 1)));
            #1;
            n_checks++;
            if (c !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: c=%h expected 0", i, c);
            end
        end
        @(negedge clk);
        drive(32'h0000_0005, 32'h0000_0007, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (c !== '0) begin
            n_fail++;
            $display("FAIL reset_release_pre_edge: c=%h expected 0", c);
        end
        wait_latency();
        n_checks++;
        if (c !== 32'h0000_000C) begin
            n_fail++;
            $display("FAIL reset_first_capture: c=%h expected 0000000c", c);
        end
    endtask

    task automatic test_async_reset();
        drive(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_latency();
        n_checks++;
        if (c !== 32'h2345_6789) begin
            n_fail++;
            $display("FAIL async_pre: c=%h expected 23456789", c);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (c !== '0) begin
            n_fail++;
            $display("FAIL async_midcycle: c=%h expected 0", c);
        end
        // Change inputs while reset is held. Nothing from before the reset
        // may come out after release.
        @(negedge clk);
        drive(32'h0000_0100, 32'h0000_0200, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (c !== '0) begin
            n_fail++;
            $display("FAIL async_no_stale: c=%h expected 0", c);
        end
        wait_latency();
        n_checks++;
        if (c !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL async_post_release: c=%h expected 00000300", c);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] da [4] = '{32'h0001_FFFF, 32'h0001_FFFF, 32'h7FFF_1234, 32'hFFFF_FFFF};
        logic [W-1:0] db [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0001_ABCD, 32'hFFFF_FFFE};
        logic         dm [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] de [4] = '{32'h0002_0000, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFD};
        for (int i = 0; i < 4; i++) begin
            drive(da[i], db[i], dm[i]);
            wait_latency();
            n_checks++;
            if (c !== de[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: c=%h expected %h", i, c, de[i]);
            end
            n_checks++;
            if (c_full !== da[i] + db[i]) begin
                n_fail++;
                $display("FAIL directed_full_%0d: c=%h expected %h", i, c_full, da[i] + db[i]);
            end
        end
    endtask

    task automatic test_random_hold();
        logic [W-1:0] x, y, e;
        for (int i = 0; i < 500; i++) begin
            x = $urandom();
            y = $urandom();
            e = model(x, y, 1'b1);
            drive(x, y, 1'b1);
            wait_latency();
            n_checks++;
            if (c !== e || c[15:0] !== 16'h0) begin
                n_fail++;
                $display("FAIL hold_first pair %0d: c=%h expected %h", i, c, e);
            end
            repeat (100 - LAT - 1) @(negedge clk);
            n_checks++;
            if (c !== e) begin
                n_fail++;
                $display("FAIL hold_stable pair %0d: c=%h expected %h", i, c, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y, got;
        logic         m;
        logic [W-1:0] full_q[$];
        exp_q.delete();
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == LAT) begin
                got = exp_q.pop_front();
                n_checks++;
                if (c !== got) begin
                    n_fail++;
                    $display("FAIL b2b pair %0d: c=%h expected %h", i - LAT, c, got);
                end
                got = full_q.pop_front();
                n_checks++;
                if (c_full !== got) begin
                    n_fail++;
                    $display("FAIL b2b_full pair %0d: c=%h expected %h", i - LAT, c_full, got);
                end
            end
            x = $urandom();
            y = $urandom();
            m = 1'(i % 2) ^ 1'($urandom_range(0, 1));
            drive(x, y, m);
            exp_q.push_back(model(x, y, m));
            full_q.push_back(x + y);
            @(negedge clk);
        end
        while (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            n_checks++;
            if (c !== got) begin
                n_fail++;
                $display("FAIL b2b_drain: c=%h expected %h", c, got);
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_directed();
        test_random_hold();
        @(negedge clk);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/config_int_add_in_mux_truncation.md
CONFIG_INT_ADD_IN_MUX_TRUNCATION -- requirements
Module: config_int_add_in_mux_truncation

Interface
REQ-001 Parameter DATA_PATH_BITWIDTH, default 32, SHALL set the operand and result width W.
REQ-002 Parameter HRDWIRED_BITWIDTH, default 16, SHALL set H, the number of upper bits always computed exactly.
- Legal range: 1 <= H <= W.
- L = W - H is the number of approximable low bits.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port apx_ctl, input, 1, SHALL select the mode: 1 = approximate (truncating), 0 = exact.
REQ-006 Port a, input, W, SHALL be operand A, two's complement.
REQ-007 Port b, input, W, SHALL be operand B, two's complement.
REQ-008 Port c, output, W, SHALL be the registered sum.

Function
REQ-009 On each rising clk edge with rst high, a, b and apx_ctl SHALL be captured into input registers a_q, b_q, apx_q.
REQ-010 An input mux SHALL form the gated operands ga and gb.
- apx_q = 1: low L bits forced to 0, upper H bits passed through.
- apx_q = 0: a_q and b_q passed unchanged.
REQ-011 The adder SHALL compute s = (ga + gb) mod 2^W.
- No carry-out, no overflow flag, no saturation.
- Signed and unsigned wrap are bit-identical.
REQ-012 In approximate mode, s[L-1:0] SHALL be 0 and s[W-1:L] SHALL equal a_q[W-1:L] + b_q[W-1:L] mod 2^H.
- No carry from the truncated bits.
REQ-013 The low-L-bit adder slice SHALL see constant-zero operands in approximate mode so it does not toggle.
REQ-014 With CFG_ADD_OUT_REG_EN defined, c SHALL be a register loaded with s.
- Latency: 2 rising edges from a/b/apx_ctl change to c.
REQ-015 Without CFG_ADD_OUT_REG_EN, c SHALL be driven combinationally from s.
- Latency: 1 rising edge.
REQ-016 A change of apx_ctl SHALL take effect on exactly the same pipeline stage as the operands sampled with it; there is no mixed-mode result.
REQ-017 Holding inputs stable SHALL yield a stable c after the latency has elapsed.
REQ-018 When H = W, apx_ctl SHALL have no effect on c.

Reset
REQ-019 rst low SHALL immediately, independent of clk, clear to 0: a_q, b_q, apx_q and the output register (if present).
- Result: c = 0 during reset.
REQ-020 Deasserting rst SHALL be synchronous to clk; the first capture occurs on the first rising edge with rst high.
REQ-021 Asserting rst mid-operation SHALL discard all in-flight results; no partial result appears after reset release.

Configuration
REQ-022 Macro CFG_ADD_OUT_REG_EN SHALL control the output register.
- Defined: output register present, latency 2 (REQ-014).
- Undefined: output register absent, latency 1 (REQ-015).
- Function is identical in both cases; only latency differs.

Verification
REQ-023 Hold rst = 0 for 30 cycles with random a/b -> c = 0 throughout; c is 0 asynchronously on rst fall mid-cycle.
REQ-024 apx_ctl = 0, a = 0x0001_FFFF, b = 0x0000_0001 -> c = 0x0002_0000 after the configured latency.
REQ-025 apx_ctl = 1, same operands -> c = 0x0001_0000, with no carry from the low half.
REQ-026 apx_ctl = 1, a = 0x7FFF_1234, b = 0x0001_ABCD -> c = 0x8000_0000, wrapping with no overflow indication.
REQ-027 apx_ctl = 0, a = 0xFFFF_FFFF (-1), b = 0xFFFF_FFFE (-2) -> c = 0xFFFF_FFFD (-3).
REQ-028 500 random pairs, each held 100 cycles with apx_ctl = 1 -> every c matches the REQ-012 model with c[15:0] = 0; then toggle apx_ctl per pair -> each result matches the mode sampled with its operands.
